// File: rtl/ucmd_router.sv
// ucmd_router: decodes validated UART bytes into toggled mode flags and stretched button pulses
module ucmd_router #(
    parameter int N_MODE = 3,
    parameter int N_BTN = 4,
    parameter int N_ALIAS = 3,
    parameter logic [8*N_MODE-1:0] MODE_CODES = {8'h43, 8'h4D, 8'h46},
    parameter logic [8*N_ALIAS*N_BTN-1:0] BTN_CODES = {
        8'h2D, 8'h00, 8'h00,
        8'h2B, 8'h00, 8'h00,
        8'h63, 8'h4C, 8'h00,
        8'h72, 8'h73, 8'h52
    },
    parameter int PULSE_LEN = 1,
    parameter int CASE_FOLD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [N_MODE-1:0] sw_mode,
    input  logic [N_BTN-1:0]  btn_in,
    input  logic              clr_err,
    output logic [N_MODE-1:0] mode_out,
    output logic [N_BTN-1:0]  btn_out,
    output logic              err_pulse,
    output logic [7:0]        err_cnt,
    output logic [7:0]        last_cmd
);
    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);

    logic [7:0]        byte_f;
    logic [N_MODE-1:0] mode_hit;
    logic [N_MODE-1:0] mode_q;
    logic [N_BTN-1:0]  btn_hit;
    logic [N_BTN-1:0]  btn_act;
    logic              any_hit;
    logic              unknown;
    logic [CW-1:0]     cnt [N_BTN];

    assign byte_f = (CASE_FOLD != 0 && rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;

    // compare the folded byte against every table slot; zero slots are unused and never match
    always_comb begin
        mode_hit = '0;
        btn_hit = '0;
        for (int i = 0; i < N_MODE; i++)
            mode_hit[i] = rx_valid && MODE_CODES[8*i+:8] != 8'h00 && byte_f == MODE_CODES[8*i+:8];
        for (int j = 0; j < N_BTN; j++)
            for (int k = 0; k < N_ALIAS; k++)
                btn_hit[j] = btn_hit[j] | (rx_valid && BTN_CODES[8*(j*N_ALIAS+k)+:8] != 8'h00
                                           && byte_f == BTN_CODES[8*(j*N_ALIAS+k)+:8]);
    end

    assign any_hit = |{mode_hit, btn_hit};
    assign unknown = rx_valid && !any_hit;

    // mode toggles on a hit; a held switch forces the stored state to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= '0;
        else mode_q <= ~sw_mode & (mode_q ^ mode_hit);
    end

    generate
        for (genvar j = 0; j < N_BTN; j++) begin : g_btn
            // a hit reloads the full stretch length, otherwise count down to idle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt[j] <= '0;
                else if (btn_hit[j]) cnt[j] <= CNT_LOAD;
                else if (cnt[j] != '0) cnt[j] <= cnt[j] - 1'b1;
            end
            assign btn_act[j] = cnt[j] != '0;
        end
    endgenerate

    // error flag, saturating error count (clear wins) and last recognised byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt <= 8'h00;
            last_cmd <= 8'h00;
        end else begin
            err_pulse <= unknown;
            err_cnt <= clr_err ? 8'h00 : (unknown && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            if (any_hit) last_cmd <= byte_f;
        end
    end

    assign mode_out = sw_mode | mode_q;
    assign btn_out = btn_in | btn_act;
endmodule
